vga_scan_reader: RTL and testbench
==================================

# vga_scan_reader

Read-side engine for the VGA frame buffer: generates 640x480@60 Hz VGA timing from the system clock and fetches the 320x240 processed image from `vga_buffer_ram` through its read address port (`row_read`, `col_read`). Each buffer pixel is displayed 2x2, so the image fills the whole visible area. The 12-bit buffer word is driven to the RGB444 DAC pins. The block sits between `vga_buffer_ram` and the board VGA connector and is the consumer counterpart of the mask pipeline that writes the buffer.

## Interface
- `CLK_DIV`, 4: system clocks per VGA pixel. 100 MHz / 4 = 25 MHz. Must be >= 2.
- `H_VISIBLE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels. Total is 800.
- `V_VISIBLE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines. Total is 525.
- `clk` in 1: system clock, the same clock that drives `vga_buffer_ram`.
- `rst_n` in 1: asynchronous, active-low reset.
- `pixel_in` in 12: buffer read data `{R[11:8],G[7:4],B[3:0]}`.
- `row_read` out 8: buffer read row, 0..239.
- `col_read` out 9: buffer read column, 0..319.
- `vga_hs` out 1: horizontal sync, active low.
- `vga_vs` out 1: vertical sync, active low.
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour outputs. Forced to 0 outside the visible area.
- `frame_start` out 1: one-`clk` pulse on the pixel tick where h=0, v=0.

## Operation
- **Divider.** A free-running counter `div` runs 0..CLK_DIV-1. The internal `pix_tick` is asserted when `div == CLK_DIV-1`. All timing state advances only on `pix_tick`.
- **Scan counters.** `h` runs 0..799 and wraps to 0. When `h` wraps, `v` increments, running 0..524 and wrapping to 0.
- **Visibility and sync.**
  - `visible = (h < 640) && (v < 480)`.
  - Sync is low for h in [656, 751] and for v in [490, 491].
- **Address generation.** On `pix_tick`:
  - `col_read <= h[9:1]` and `row_read <= v[8:1]` when visible.
  - Otherwise both hold their last value.
- **Pipeline stage.** One `pix_tick` after addressing, on the next `pix_tick`, the block registers:
  - `vga_hs` and `vga_vs` (delayed one pixel);
  - RGB as `visible_d ? pixel_in : 12'h000`.
  - Sync and colour therefore stay aligned.
- **Arithmetic.** All comparisons are unsigned. The `h` and `v` counters are 10 bits wide. No other arithmetic is performed.

## Timing
- **Reset values.** On `rst_n` low, asynchronously:
  - `div`, `h`, `v` = 0;
  - `row_read`, `col_read` = 0;
  - `vga_hs`, `vga_vs` = 1;
  - RGB = 0;
  - `frame_start` = 0;
  - `visible_d` = 0.
- **Reset release.** The first `pix_tick` occurs CLK_DIV cycles after `rst_n` rises.
- **Buffer read latency.** The buffer registers the address on `clk` and reads combinationally, giving 1 `clk` of latency. Because CLK_DIV >= 2, `pixel_in` is stable before the next `pix_tick` samples it. No extra handshake is used.
- **Output latency.** From a counter value to the pins: 1 pixel (CLK_DIV clks) for sync and colour.
- **Outputs between ticks.** All outputs change only on the `clk` edge where `pix_tick` = 1. The exception is `frame_start`, which is high for exactly that one `clk` and low otherwise.
- **Wrap-around.** h=799 → 0 with v++. At h=799, v=524, both counters wrap to 0 and the next tick raises `frame_start`.
- **Reset mid-frame.** Reset mid-frame restarts at h=v=0. No partial sync pulse is extended: hs/vs go high immediately.
- **Frame period.** 800 × 525 × CLK_DIV clks, i.e. 1,680,000 at the default CLK_DIV.

## Structure
- **Shared constants.** `IMAGE_WIDTH` (320) and `IMAGE_HEIGHT` (240) stay in `utils.v`. The VGA timing defaults (`VGA_H_*`, `VGA_V_*`) are added there, and the parameters default to them.
- **Sub-module.** `vga_timing_gen` holds the divider, h/v counters, `visible`, raw syncs and `pix_tick`.
- **Top level.** `vga_scan_reader` instantiates it and adds the address registers, pipeline delay and colour gating.

## Test plan
- **Reset.** Hold `rst_n`=0 for 10 clks with `pixel_in`=12'hFFF → hs=vs=1, RGB=0, `row_read`=0, `col_read`=0. After release, the first tick is at clk 4.
- **Horizontal timing.** Measure `vga_hs` → low for 96×4=384 clks, period 800×4=3200 clks, falling edge 657 pixels after `frame_start`. The 657 is h=656 plus the 1-pixel delay.
- **Vertical timing.** Measure `vga_vs` → low for 2 lines (6400 clks), period 525 lines. `frame_start` occurs once per 1,680,000 clks.
- **Address mapping.** At pixel (h=5, v=7) → `col_read`=2, `row_read`=3. At (639, 479) → `col_read`=319, `row_read`=239. During blanking the addresses hold.
- **Colour path.** Use a buffer model returning `{row[3:0], col[3:0], 4'hA}` with 1-clk latency → at displayed pixel (h=10, v=4), RGB = `{4'h2, 4'h5, 4'hA}`, sampled one pixel later. At h=640..799 RGB = 0.
- **Reset mid-line.** Assert `rst_n` low at h=700, during sync → `vga_hs` goes to 1 within the same clk. After release, timing restarts from h=0 and `frame_start` pulses on the first tick.

Source files
------------

// File: rtl/vga_scan_reader_pkg.sv
// vga_scan_reader_pkg: shared image geometry, VGA timing defaults and port widths
package vga_scan_reader_pkg;
    localparam int IMAGE_WIDTH   = 320;
    localparam int IMAGE_HEIGHT  = 240;
    localparam int VGA_CLK_DIV   = 4;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int PIX_W         = 12;
    localparam int ROW_W         = 8;
    localparam int COL_W         = 9;
    localparam int CNT_W         = 10;
endpackage

// File: rtl/vga_scan_reader_if.sv
// vga_scan_reader_if: frame-buffer read port plus VGA connector pins
interface vga_scan_reader_if;
    import vga_scan_reader_pkg::*;
    logic [PIX_W-1:0] pixel_in;
    logic [ROW_W-1:0] row_read;
    logic [COL_W-1:0] col_read;
    logic             vga_hs;
    logic             vga_vs;
    logic [3:0]       vga_r;
    logic [3:0]       vga_g;
    logic [3:0]       vga_b;
    logic             frame_start;
    modport master (
        input  pixel_in,
        output row_read, col_read, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
    );
    modport slave (
        output pixel_in,
        input  row_read, col_read, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_scan_reader_timing_gen.sv
// vga_timing_gen: pixel-rate divider, h/v scan counters, visibility and raw active-low syncs
import vga_scan_reader_pkg::*;
module vga_timing_gen #(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_tick,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             visible,
    output logic             hsync,
    output logic             vsync
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = CLK_DIV > 2 ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;

    assign pix_tick = div == DIV_W'(CLK_DIV - 1);
    assign visible  = h < CNT_W'(H_VISIBLE) && v < CNT_W'(V_VISIBLE);
    assign hsync    = !(h >= HS_LO && h <= HS_HI);
    assign vsync    = !(v >= VS_LO && v <= VS_HI);

    // free-running divider producing one pixel tick every CLK_DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= pix_tick ? '0 : div + DIV_W'(1);
    end

    // raster scan: h wraps at end of line, v advances on each h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (pix_tick) begin
            h <= h == H_LAST ? '0 : h + CNT_W'(1);
            if (h == H_LAST) v <= v == V_LAST ? '0 : v + CNT_W'(1);
        end
    end
endmodule

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: scans the 320x240 buffer at 2x2 onto 640x480@60 VGA with aligned sync and colour
import vga_scan_reader_pkg::*;
module vga_scan_reader #(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input logic               clk,
    input logic               rst_n,
    vga_scan_reader_if.master bus
);
    logic             pix_tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             visible;
    logic             hsync;
    logic             vsync;
    logic             visible_d;
    logic             hs_d;
    logic             vs_d;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .h(h), .v(v),
        .visible(visible), .hsync(hsync), .vsync(vsync)
    );

    // address stage: 2x2 upscale by dropping the LSB; hold address through blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.row_read <= '0;
            bus.col_read <= '0;
            visible_d    <= 1'b0;
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
        end else if (pix_tick) begin
            if (visible) begin
                bus.col_read <= h[9:1];
                bus.row_read <= v[8:1];
            end
            visible_d <= visible;
            hs_d      <= hsync;
            vs_d      <= vsync;
        end
    end

    // output stage: syncs delayed alongside the buffer read so pins stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vga_hs <= 1'b1;
            bus.vga_vs <= 1'b1;
            {bus.vga_r, bus.vga_g, bus.vga_b} <= '0;
        end else if (pix_tick) begin
            bus.vga_hs <= hs_d;
            bus.vga_vs <= vs_d;
            {bus.vga_r, bus.vga_g, bus.vga_b} <= visible_d ? bus.pixel_in : '0;
        end
    end

    // single-clock strobe on the tick that scans the top-left pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.frame_start <= 1'b0;
        else        bus.frame_start <= pix_tick && h == '0 && v == '0;
    end
endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader: closed-form raster model checked every clock on a full-size and a shrunken-timing instance
module tb_vga_scan_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic hold_fff = 1'b1;
    logic run = 1'b0;
    logic meas = 1'b0;
    int   c = 0;
    int   gc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    vga_scan_reader_if bd ();
    vga_scan_reader_if bs ();

    vga_scan_reader u_def (.clk(clk), .rst_n(rst_n), .bus(bd));
    vga_scan_reader #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (.clk(clk), .rst_n(rst_n), .bus(bs));

    always #5 clk = ~clk;

    logic [7:0] ra_d = '0, ra_s = '0;
    logic [8:0] ca_d = '0, ca_s = '0;
    always @(posedge clk) begin
        ra_d <= bd.row_read;
        ca_d <= bd.col_read;
        ra_s <= bs.row_read;
        ca_s <= bs.col_read;
    end
    assign bd.pixel_in = hold_fff ? 12'hFFF : {ra_d[3:0], ca_d[3:0], 4'hA};
    assign bs.pixel_in = hold_fff ? 12'hFFF : {ra_s[3:0], ca_s[3:0], 4'hA};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c <= 0;
        else        c <= c + 1;
    end
    always @(posedge clk) gc <= gc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // expected {hs, vs, rgb, frame_start, row, col} given clocks elapsed since reset release
    function automatic logic [31:0] model(input int cc, input int dv, input int hv, input int hf,
                                          input int hsn, input int hb, input int vv, input int vf,
                                          input int vsn, input int vb);
        int ht, vt, t, pe, h, v, q, qh, qv, lh, lv;
        logic hs, vs, fs;
        logic [11:0] rgb;
        logic [7:0] row;
        logic [8:0] col;
        ht = hv + hf + hsn + hb;
        vt = vv + vf + vsn + vb;
        t = cc / dv;
        hs = 1'b1; vs = 1'b1; fs = 1'b0; rgb = '0; row = '0; col = '0;
        if (t > 0) begin
            pe = (t - 1) % (ht * vt);
            h = pe % ht;
            v = pe / ht;
            fs = (cc % dv == 0) && pe == 0;
            lh = (h < hv && v < vv) ? h : hv - 1;
            lv = v < vv ? v : vv - 1;
            col = 9'(lh / 2);
            row = 8'(lv / 2);
            if (t > 1) begin
                q = (t - 2) % (ht * vt);
                qh = q % ht;
                qv = q / ht;
                hs = !(qh >= hv + hf && qh < hv + hf + hsn);
                vs = !(qv >= vv + vf && qv < vv + vf + vsn);
                rgb = (qh < hv && qv < vv) ? {4'((qv / 2) % 16), 4'((qh / 2) % 16), 4'hA} : 12'h000;
            end
        end
        return {hs, vs, rgb, fs, row, col};
    endfunction

    // every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (run) begin
            check("model_def", {bd.vga_hs, bd.vga_vs, bd.vga_r, bd.vga_g, bd.vga_b, bd.frame_start, bd.row_read, bd.col_read},
                  model(c, 4, 640, 16, 96, 48, 480, 10, 2, 33));
            check("model_small", {bs.vga_hs, bs.vga_vs, bs.vga_r, bs.vga_g, bs.vga_b, bs.frame_start, bs.row_read, bs.col_read},
                  model(c, 2, 16, 2, 3, 3, 8, 1, 2, 2));
        end
    end

    // edge-time recorder for sync and frame_start waveforms
    logic ph = 1'b1, pfs = 1'b0, pvs = 1'b1, psfs = 1'b0;
    int t_fs = -1, t_f1 = -1, t_r1 = -1, t_f2 = -1;
    int s_f1 = -1, s_r1 = -1, s_f2 = -1, s_fs1 = -1, s_fs2 = -1;
    always @(negedge clk) begin
        if (meas) begin
            if (bd.frame_start && !pfs && t_fs < 0) t_fs = gc;
            if (!bd.vga_hs && ph) begin
                if (t_f1 < 0) t_f1 = gc;
                else if (t_f2 < 0) t_f2 = gc;
            end
            if (bd.vga_hs && !ph && t_f1 >= 0 && t_r1 < 0) t_r1 = gc;
            if (!bs.vga_vs && pvs) begin
                if (s_f1 < 0) s_f1 = gc;
                else if (s_f2 < 0) s_f2 = gc;
            end
            if (bs.vga_vs && !pvs && s_f1 >= 0 && s_r1 < 0) s_r1 = gc;
            if (bs.frame_start && !psfs) begin
                if (s_fs1 < 0) s_fs1 = gc;
                else if (s_fs2 < 0) s_fs2 = gc;
            end
            ph = bd.vga_hs; pfs = bd.frame_start; pvs = bs.vga_vs; psfs = bs.frame_start;
        end
    end

    task automatic wait_c(input int target);
        int g = 0;
        while (c < target && g < 100000) begin
            @(negedge clk);
            g++;
        end
        if (c != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_c: reached %0d required %0d", c, target);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        run = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_def", {bd.vga_hs, bd.vga_vs, bd.vga_r, bd.vga_g, bd.vga_b, bd.frame_start, bd.row_read, bd.col_read}, {2'b11, 30'd0});
        check("rst_small", {bs.vga_hs, bs.vga_vs, bs.vga_r, bs.vga_g, bs.vga_b, bs.frame_start, bs.row_read, bs.col_read}, {2'b11, 30'd0});
        rst_n = 1'b1;
        hold_fff = 1'b0;
        meas = 1'b1;
        wait_c(2);
        check("fs_small_first", 32'(bs.frame_start), 32'd1);
        check("fs_def_c2", 32'(bd.frame_start), 32'd0);
        wait_c(3);
        check("fs_def_c3", 32'(bd.frame_start), 32'd0);
        wait_c(4);
        check("fs_def_first", 32'(bd.frame_start), 32'd1);
        wait_c(5);
        check("fs_def_one_clk", 32'(bd.frame_start), 32'd0);
        wait_c(368);
        check("addr_small_last", {bs.row_read, bs.col_read}, {8'd3, 9'd7});
        wait_c(378);
        check("addr_small_hblank", {bs.row_read, bs.col_read}, {8'd3, 9'd7});
        wait_c(434);
        check("addr_small_vblank", {bs.row_read, bs.col_read}, {8'd3, 9'd7});
        wait_c(2804);
        check("addr_def_hblank", {bd.row_read, bd.col_read}, {8'd0, 9'd319});
        wait_c(12848);
        check("rgb_10_4", {bd.vga_r, bd.vga_g, bd.vga_b}, 32'h25A);
        wait_c(15608);
        check("rgb_blank_700", {bd.vga_r, bd.vga_g, bd.vga_b}, 32'h000);
        wait_c(22424);
        check("addr_5_7", {bd.row_read, bd.col_read}, {8'd3, 9'd2});
        wait_c(28402);
        meas = 1'b0;
        check("hs_fall_after_fs", t_f1 - t_fs, 32'd2628);
        check("hs_low_width", t_r1 - t_f1, 32'd384);
        check("hs_period", t_f2 - t_f1, 32'd3200);
        check("vs_low_small", s_r1 - s_f1, 32'd96);
        check("vs_period_small", s_f2 - s_f1, 32'd624);
        check("fs_period_small", s_fs2 - s_fs1, 32'd624);
        check("hs_low_at_700", 32'(bd.vga_hs), 32'd0);
        rst_n = 1'b0;
        #1;
        check("hs_async_high", 32'(bd.vga_hs), 32'd1);
        check("addr_async_zero", {bd.row_read, bd.col_read}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_c(4);
        check("fs_after_midreset", 32'(bd.frame_start), 32'd1);
        wait_c(200);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
